npu_mac_array: RTL and testbench
================================

Name: npu_mac_array

Overview:
- Parametrised multi-lane successor of the NPU MAC.
- NUM_LANES output channels share one broadcast activation stream. Each lane has its own weight and bias.
- Each lane multiplies, accumulates with guard bits, then quantizes with optional rounding, adds bias, saturates and applies optional ReLU.
- Sits between the weight/activation fetch logic and the layer output buffer.
- Also owns the bias-RAM address that advances per layer.

Parameters:
DATA_WIDTH, 8, signed width of weight, activation, bias and output
NUM_FRAC_BITS, 5, fractional bits of the fixed-point format
NUM_LANES, 4, parallel output channels
ACC_WIDTH, 2*DATA_WIDTH+4, signed accumulator width; the extra bits are guard bits
BIAS_ADDR_WIDTH, 3, width of the bias RAM address

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
mac_en  in  1  input beat valid; inputs are ignored when low
start_p  in  1  first beat of a frame, qualified by mac_en
last_p  in  1  last beat of a frame, qualified by mac_en
weight_in  in  NUM_LANES*DATA_WIDTH  signed weights; lane i is at bits [i*DATA_WIDTH +: DATA_WIDTH]
act_in  in  DATA_WIDTH  signed activation, broadcast to all lanes
round_en  in  1  round half-up on quantization; sampled with last_p
relu_en  in  1  clamp negative outputs to 0; sampled with last_p
npu_layer_in_progress  in  3  current layer index; 0 means idle
bias_rd_addr  out  BIAS_ADDR_WIDTH  bias RAM address
bias_rd_data  in  NUM_LANES*DATA_WIDTH  signed per-lane bias
mac_out  out  NUM_LANES*DATA_WIDTH  signed quantized results, held until the next mac_valid
mac_valid  out  1  one-cycle pulse; mac_out is valid in that cycle
mac_overflow  out  NUM_LANES  per-lane frame overflow flag, updated together with mac_valid

Behaviour:
- Reset: one clock; reset is synchronous and active-high. The following all clear to 0:
  - all pipeline registers and accumulators;
  - mac_out, mac_valid, mac_overflow and bias_rd_addr.
- Reset mid-frame: the frame is dropped and no mac_valid is produced for it.
- Pipeline: S1 registers products. S2 accumulates. S3 quantizes and registers the outputs.
- Latency: an accepted beat with last_p at cycle T gives a mac_valid pulse at T+3.
- Back-to-back frames are legal: a start_p beat may directly follow a last_p beat.
- Beat handling:
  - Beats with mac_en=0 do not change the accumulators and do not advance control.
  - Gaps inside a frame are legal.
- S2 accumulate rule:
  - A start beat loads the accumulator with the product.
  - Any other valid beat adds the product to the accumulator.
  - start_p and last_p together form a one-beat frame.
  - start_p in mid-frame discards the partial sum and restarts the frame.
  - last_p without a prior start continues from the held accumulator value.
- Accumulator overflow:
  - The accumulator saturates to the ACC_WIDTH min or max.
  - Saturation sets the lane's overflow-pending bit.
  - Overflow-pending clears on the start beat.
- S3 arithmetic, per lane:
  - q = (acc + (round_en ? 2^(NUM_FRAC_BITS-1) : 0)) >>> NUM_FRAC_BITS, as an arithmetic shift.
  - s = q + sign-extended bias.
  - The result is saturated to the DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - relu_en forces negative results to 0. ReLU is applied after saturation.
- mac_overflow[i]:
  - Set if lane i's overflow-pending bit is set or S3 saturated.
  - Loaded only on mac_valid and held otherwise.
- bias_rd_data timing:
  - Sampled in S3.
  - It must be stable from the frame's first beat onward; the RAM address changes only on layer transitions.
- Bias address:
  - layer==0 forces bias_rd_addr to 0.
  - It increments by 1 when the layer changes and the previous layer was non-zero.
  - It wraps modulo 2^BIAS_ADDR_WIDTH.
  - The previous layer is a registered copy that clears on reset.

Decomposition:
- Shared package npu_pkg:
  - the fixed-point defaults (DATA_WIDTH, NUM_FRAC_BITS);
  - the ACC_WIDTH guard-bit constant;
  - saturation functions sat_acc() and sat_out().
- Sub-module npu_mac_lane, instantiated NUM_LANES times. It holds the S1 multiply, S2 accumulate and overflow-pending logic, and the S3 quantize/bias/saturate/ReLU stage.
- The top level holds:
  - the control pipeline (start, last, valid, round_en and relu_en delays);
  - the bias-address tracker;
  - the lane-slicing of the buses.

Test Plan:
- One-beat frame, all lanes w=32, a=32, bias=0, round off: start+last at T -> mac_valid one pulse at T+3, mac_out=32 in every lane, mac_overflow=0.
- Four beats w=16, a=32, bias=8 (lane 1 w=-16, bias 0), with a mac_en=0 gap after beat 2 -> lane 0=72, lane 1=-64.
- Saturation:
  - 4 beats w=127, a=127 -> 127, mac_overflow bit set.
  - Lane 1 with w=-128 -> -128, bit set.
  - A following clean frame clears both bits.
- Rounding and ReLU:
  - w=1, a=16: round off -> 0, round on -> 1.
  - w=-32, a=32: relu off -> -32, relu on -> 0.
- Bias address:
  - Layer sequence 0,1,2,3,0 -> bias_rd_addr 0,0,1,2,0.
  - With BIAS_ADDR_WIDTH=3, nine layer steps wrap to 0.
- Control corners:
  - rst asserted mid-frame -> no mac_valid and all outputs 0.
  - start_p re-asserted mid-frame -> only the beats after the restart are summed.
  - Back-to-back frames -> two mac_valid pulses one cycle apart.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared fixed-point defaults, bus control types and saturation helpers for the NPU MAC array.
package npu_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 8;
    localparam int unsigned DEF_NUM_FRAC_BITS   = 5;
    localparam int unsigned DEF_NUM_LANES       = 4;
    localparam int unsigned GUARD_BITS          = 4;
    localparam int unsigned DEF_ACC_WIDTH       = 2 * DEF_DATA_WIDTH + GUARD_BITS;
    localparam int unsigned DEF_BIAS_ADDR_WIDTH = 3;
    localparam int unsigned LAYER_WIDTH         = 3;

    // Wide signed working width so intermediate sums never wrap before saturation.
    localparam int unsigned CALC_WIDTH = 64;
    typedef logic signed [CALC_WIDTH-1:0] calc_t;

    // Beat control as captured in S1.
    typedef struct packed {
        logic vld;
        logic start;
        logic last;
        logic round_en;
        logic relu_en;
    } s1_ctl_t;

    // Control that travels on to the output stage.
    typedef struct packed {
        logic last;
        logic round_en;
        logic relu_en;
    } s2_ctl_t;

    // Clamp x to the signed range of a w-bit number.
    function automatic calc_t sat_range(input calc_t x, input int unsigned w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -(calc_t'(1) <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Accumulator saturation to the guard-bit accumulator range.
    function automatic calc_t sat_acc(input calc_t x, input int unsigned acc_w);
        return sat_range(x, acc_w);
    endfunction

    // Output saturation to the data range.
    function automatic calc_t sat_out(input calc_t x, input int unsigned data_w);
        return sat_range(x, data_w);
    endfunction

endpackage

// File: rtl/npu_mac_array_if.sv
// Beat, bias-RAM and result signals between fetch logic, the MAC array and the output buffer.
interface npu_mac_array_if #(
    parameter int unsigned NUM_LANES       = npu_pkg::DEF_NUM_LANES,
    parameter int unsigned DATA_WIDTH      = npu_pkg::DEF_DATA_WIDTH,
    parameter int unsigned BIAS_ADDR_WIDTH = npu_pkg::DEF_BIAS_ADDR_WIDTH
);
    logic                              mac_en;
    logic                              start_p;
    logic                              last_p;
    logic [NUM_LANES*DATA_WIDTH-1:0]   weight_in;
    logic [DATA_WIDTH-1:0]             act_in;
    logic                              round_en;
    logic                              relu_en;
    logic [npu_pkg::LAYER_WIDTH-1:0]   npu_layer_in_progress;
    logic [BIAS_ADDR_WIDTH-1:0]        bias_rd_addr;
    logic [NUM_LANES*DATA_WIDTH-1:0]   bias_rd_data;
    logic [NUM_LANES*DATA_WIDTH-1:0]   mac_out;
    logic                              mac_valid;
    logic [NUM_LANES-1:0]              mac_overflow;

    modport master (
        output mac_en, start_p, last_p, weight_in, act_in, round_en, relu_en,
               npu_layer_in_progress, bias_rd_data,
        input  bias_rd_addr, mac_out, mac_valid, mac_overflow
    );

    modport slave (
        input  mac_en, start_p, last_p, weight_in, act_in, round_en, relu_en,
               npu_layer_in_progress, bias_rd_data,
        output bias_rd_addr, mac_out, mac_valid, mac_overflow
    );
endinterface

// File: rtl/npu_mac_lane.sv
// One output channel: S1 multiply, S2 saturating accumulate, S3 quantize/bias/saturate/ReLU.
module npu_mac_lane
    import npu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned NUM_FRAC_BITS = DEF_NUM_FRAC_BITS,
    parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         beat_en,
    input  logic signed [DATA_WIDTH-1:0] weight,
    input  logic signed [DATA_WIDTH-1:0] act,
    input  logic                         acc_en,
    input  logic                         acc_load,
    input  logic                         out_load,
    input  logic                         round_en,
    input  logic                         relu_en,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [DATA_WIDTH-1:0] lane_out,
    output logic                         lane_ovf
);
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod_q, prod_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         ovf_pend_q, ovf_pend_d;
    logic signed [DATA_WIDTH-1:0] out_q, out_d;
    logic                         ovf_q, ovf_d;

    calc_t acc_sum, acc_sat;
    calc_t rnd_add, quant, biased, out_sat, out_fin;

    // S1: register the product of a valid beat.
    always_comb begin
        prod_d = prod_q;
        if (beat_en) begin
            prod_d = PROD_WIDTH'(weight) * PROD_WIDTH'(act);
        end
    end

    // S2: load on a start beat, otherwise add; saturation marks the frame as overflowed.
    always_comb begin
        acc_d      = acc_q;
        ovf_pend_d = ovf_pend_q;
        acc_sum    = acc_load ? calc_t'(prod_q) : calc_t'(acc_q) + calc_t'(prod_q);
        acc_sat    = sat_acc(acc_sum, ACC_WIDTH);
        if (acc_en) begin
            acc_d      = ACC_WIDTH'(acc_sat);
            ovf_pend_d = (acc_sat != acc_sum) | (~acc_load & ovf_pend_q);
        end
    end

    // S3: quantize, add bias, saturate, then ReLU; result and flag load only on frame end.
    always_comb begin
        out_d   = out_q;
        ovf_d   = ovf_q;
        rnd_add = round_en ? (calc_t'(1) <<< (NUM_FRAC_BITS - 1)) : calc_t'(0);
        quant   = (calc_t'(acc_q) + rnd_add) >>> NUM_FRAC_BITS;
        biased  = quant + calc_t'(bias);
        out_sat = sat_out(biased, DATA_WIDTH);
        out_fin = (relu_en && out_sat[CALC_WIDTH-1]) ? calc_t'(0) : out_sat;
        if (out_load) begin
            out_d = DATA_WIDTH'(out_fin);
            ovf_d = ovf_pend_q | (out_sat != biased);
        end
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            acc_q      <= '0;
            ovf_pend_q <= 1'b0;
            out_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            ovf_pend_q <= ovf_pend_d;
            out_q      <= out_d;
            ovf_q      <= ovf_d;
        end
    end

    assign lane_out = out_q;
    assign lane_ovf = ovf_q;
endmodule

// File: rtl/npu_mac_array.sv
// Multi-lane NPU MAC: shared activation, per-lane weight/bias, control pipeline and bias-RAM address.
module npu_mac_array
    import npu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned NUM_FRAC_BITS   = DEF_NUM_FRAC_BITS,
    parameter int unsigned NUM_LANES       = DEF_NUM_LANES,
    parameter int unsigned ACC_WIDTH       = 2 * DATA_WIDTH + GUARD_BITS,
    parameter int unsigned BIAS_ADDR_WIDTH = DEF_BIAS_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    npu_mac_array_if.slave   bus
);
    s1_ctl_t                    s1_q, s1_d;
    s2_ctl_t                    s2_q, s2_d;
    logic                       mac_valid_q, mac_valid_d;
    logic [BIAS_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LAYER_WIDTH-1:0]     layer_prev_q, layer_prev_d;

    // Control pipeline: beat qualifiers follow the data through S1 and S2; valid pulses out of S3.
    always_comb begin
        s1_d          = '0;
        s1_d.vld      = bus.mac_en;
        s1_d.start    = bus.mac_en & bus.start_p;
        s1_d.last     = bus.mac_en & bus.last_p;
        s1_d.round_en = bus.round_en;
        s1_d.relu_en  = bus.relu_en;
        s2_d          = '0;
        s2_d.last     = s1_q.last;
        s2_d.round_en = s1_q.round_en;
        s2_d.relu_en  = s1_q.relu_en;
        mac_valid_d   = s2_q.last;
    end

    // Bias address: zero while idle, steps on each change between active layers.
    always_comb begin
        addr_d       = addr_q;
        layer_prev_d = bus.npu_layer_in_progress;
        if (bus.npu_layer_in_progress == '0) begin
            addr_d = '0;
        end else if ((bus.npu_layer_in_progress != layer_prev_q) && (layer_prev_q != '0)) begin
            addr_d = addr_q + BIAS_ADDR_WIDTH'(1);
        end
    end

    // Control and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            mac_valid_q  <= 1'b0;
            addr_q       <= '0;
            layer_prev_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            mac_valid_q  <= mac_valid_d;
            addr_q       <= addr_d;
            layer_prev_q <= layer_prev_d;
        end
    end

    assign bus.mac_valid    = mac_valid_q;
    assign bus.bias_rd_addr = addr_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        npu_mac_lane #(
            .DATA_WIDTH    (DATA_WIDTH),
            .NUM_FRAC_BITS (NUM_FRAC_BITS),
            .ACC_WIDTH     (ACC_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .beat_en  (bus.mac_en),
            .weight   (bus.weight_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .act      (bus.act_in),
            .acc_en   (s1_q.vld),
            .acc_load (s1_q.start),
            .out_load (s2_q.last),
            .round_en (s2_q.round_en),
            .relu_en  (s2_q.relu_en),
            .bias     (bus.bias_rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .lane_out (bus.mac_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .lane_ovf (bus.mac_overflow[i])
        );
    end
endmodule

// File: tb/tb_npu_mac_array.sv
// Directed bench for npu_mac_array with a behavioural lane model and a result scoreboard.
module tb_npu_mac_array;
    localparam int unsigned NL  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned FB  = 5;
    localparam int unsigned AW  = 2 * DW + 4;
    localparam int unsigned BAW = 3;

    typedef struct {
        logic [NL*DW-1:0] out;
        logic [NL-1:0]    ovf;
        int               cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    npu_mac_array_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .BIAS_ADDR_WIDTH(BAW)) bus ();

    npu_mac_array #(
        .DATA_WIDTH(DW), .NUM_FRAC_BITS(FB), .NUM_LANES(NL), .ACC_WIDTH(AW), .BIAS_ADDR_WIDTH(BAW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   cyc = 0;
    res_t obs_q[$];
    res_t exp_q[$];
    int   rd_idx = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic signed [DW-1:0] tw [NL];
    logic signed [DW-1:0] tb_b [NL];
    bit     rnd, rel;
    longint macc [NL];
    bit     mpend [NL];
    int     layer_m, prev_m, addr_m;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every result pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (bus.mac_valid === 1'b1) obs_q.push_back('{bus.mac_out, bus.mac_overflow, cyc});
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; en=1 is a beat that also advances the model.
    task automatic drive(input bit en, input bit s, input bit l, input int a);
        res_t   e;
        longint p, sum, v, sv;
        bit     sf;
        @(negedge clk);
        bus.mac_en   = en;
        bus.start_p  = s;
        bus.last_p   = l;
        bus.act_in   = DW'(a);
        bus.round_en = rnd;
        bus.relu_en  = rel;
        for (int i = 0; i < NL; i++) begin
            bus.weight_in[i*DW +: DW]    = tw[i];
            bus.bias_rd_data[i*DW +: DW] = tb_b[i];
        end
        if (en) begin
            for (int i = 0; i < NL; i++) begin
                p   = longint'(tw[i]) * longint'(a);
                sum = s ? p : macc[i] + p;
                sf  = 1'b0;
                if (sum > (64'sd1 <<< (AW - 1)) - 1) begin sum = (64'sd1 <<< (AW - 1)) - 1; sf = 1'b1; end
                if (sum < -(64'sd1 <<< (AW - 1)))    begin sum = -(64'sd1 <<< (AW - 1));    sf = 1'b1; end
                macc[i]  = sum;
                mpend[i] = s ? sf : (mpend[i] | sf);
            end
            if (l) begin
                for (int i = 0; i < NL; i++) begin
                    v  = macc[i] + (rnd ? longint'(1 <<< (FB - 1)) : 64'sd0);
                    sv = (v >>> FB) + longint'(tb_b[i]);
                    sf = 1'b0;
                    if (sv > 127)  begin sv = 127;  sf = 1'b1; end
                    if (sv < -128) begin sv = -128; sf = 1'b1; end
                    if (rel && sv < 0) sv = 0;
                    e.out[i*DW +: DW] = DW'(sv);
                    e.ovf[i]          = mpend[i] | sf;
                end
                e.cyc = cyc + 3;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    // Drain the scoreboard against captured results, then confirm no stray pulses follow.
    task automatic check_results(input string tag);
        res_t e, o;
        int   need, guard;
        idle(1);
        need  = rd_idx + exp_q.size();
        guard = 0;
        while (obs_q.size() < need && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(need));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin
                o = obs_q[rd_idx];
                rd_idx++;
                for (int i = 0; i < NL; i++)
                    chk($sformatf("%s_lane%0d", tag, i), 64'($signed(o.out[i*DW +: DW])), 64'($signed(e.out[i*DW +: DW])));
                chk({tag, "_ovf"}, 64'(o.ovf), 64'(e.ovf));
                chk({tag, "_cycle"}, 64'(o.cyc), 64'(e.cyc));
            end
        end
        idle(3);
        chk({tag, "_no_extra"}, 64'(obs_q.size()), 64'(rd_idx));
    endtask

    task automatic set_all(input int w, input int b);
        for (int i = 0; i < NL; i++) begin
            tw[i]   = DW'(w);
            tb_b[i] = DW'(b);
        end
    endtask

    task automatic step_layer(input int l);
        @(negedge clk);
        bus.npu_layer_in_progress = 3'(l);
        if (l == 0) addr_m = 0;
        else if (l != prev_m && prev_m != 0) addr_m = (addr_m + 1) % (1 << BAW);
        prev_m = l;
        @(negedge clk);
        chk($sformatf("bias_addr_layer%0d", l), 64'(bus.bias_rd_addr), 64'(addr_m));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.mac_en = 1'b0; bus.start_p = 1'b0; bus.last_p = 1'b0;
        bus.weight_in = '0; bus.act_in = '0; bus.round_en = 1'b0; bus.relu_en = 1'b0;
        bus.npu_layer_in_progress = '0; bus.bias_rd_data = '0;
        rnd = 1'b0; rel = 1'b0; prev_m = 0; addr_m = 0; layer_m = 0;
        for (int i = 0; i < NL; i++) begin macc[i] = 0; mpend[i] = 1'b0; end
        set_all(0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mac_out", 64'(bus.mac_out), 64'd0);
        chk("rst_mac_valid", 64'(bus.mac_valid), 64'd0);
        chk("rst_mac_overflow", 64'(bus.mac_overflow), 64'd0);
        chk("rst_bias_addr", 64'(bus.bias_rd_addr), 64'd0);

        // One-beat frame.
        set_all(32, 0);
        drive(1'b1, 1'b1, 1'b1, 32);
        check_results("one_beat");

        // Four beats with a gap, lane 1 negative weight and no bias.
        set_all(16, 8);
        tw[1] = -8'sd16; tb_b[1] = 8'sd0;
        drive(1'b1, 1'b1, 1'b0, 32);
        drive(1'b1, 1'b0, 1'b0, 32);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 32);
        drive(1'b1, 1'b0, 1'b1, 32);
        check_results("gap_frame");

        // Output saturation both ways, then a clean frame clears the flags.
        set_all(127, 0);
        tw[1] = -8'sd128;
        drive(1'b1, 1'b1, 1'b0, 127);
        drive(1'b1, 1'b0, 1'b0, 127);
        drive(1'b1, 1'b0, 1'b0, 127);
        drive(1'b1, 1'b0, 1'b1, 127);
        check_results("saturate");
        set_all(32, 0);
        drive(1'b1, 1'b1, 1'b1, 32);
        check_results("clean_after_sat");

        // Rounding off then on.
        set_all(1, 0);
        drive(1'b1, 1'b1, 1'b1, 16);
        rnd = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 16);
        rnd = 1'b0;
        check_results("rounding");

        // ReLU off then on, mixed signs across lanes.
        set_all(-32, 0);
        tw[1] = 8'sd32; tw[3] = 8'sd32;
        drive(1'b1, 1'b1, 1'b1, 32);
        rel = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32);
        rel = 1'b0;
        check_results("relu");

        // Restart mid-frame keeps only the later beats.
        set_all(16, 0);
        drive(1'b1, 1'b1, 1'b0, 32);
        drive(1'b1, 1'b0, 1'b0, 32);
        drive(1'b1, 1'b1, 1'b0, 8);
        drive(1'b1, 1'b0, 1'b1, 8);
        check_results("restart");

        // Back-to-back frames, then a last beat with no start continues the held sum.
        set_all(32, 0);
        drive(1'b1, 1'b1, 1'b1, 32);
        drive(1'b1, 1'b1, 1'b1, 64);
        drive(1'b1, 1'b0, 1'b1, 32);
        check_results("back_to_back");
        if (rd_idx >= 3)
            chk("b2b_gap", 64'(obs_q[rd_idx-2].cyc - obs_q[rd_idx-3].cyc), 64'd1);

        // Reset while the frame's last beat is in flight.
        set_all(16, 0);
        drive(1'b1, 1'b1, 1'b0, 32);
        @(negedge clk);
        bus.mac_en = 1'b1; bus.start_p = 1'b0; bus.last_p = 1'b1;
        @(negedge clk);
        rst = 1'b1; bus.mac_en = 1'b0; bus.last_p = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NL; i++) begin macc[i] = 0; mpend[i] = 1'b0; end
        idle(5);
        chk("midrst_no_valid", 64'(obs_q.size()), 64'(rd_idx));
        chk("midrst_mac_out", 64'(bus.mac_out), 64'd0);
        chk("midrst_mac_overflow", 64'(bus.mac_overflow), 64'd0);
        chk("midrst_mac_valid", 64'(bus.mac_valid), 64'd0);

        // Bias address over a layer sequence, then a full wrap.
        step_layer(0); step_layer(1); step_layer(2); step_layer(3); step_layer(0);
        for (int k = 0; k < 9; k++) step_layer((k % 7) + 1);
        chk("bias_addr_wrapped", 64'(bus.bias_rd_addr), 64'd0);
        step_layer(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
